// File: rtl/ctrl_seq_pkg.sv
// Shared types and default widths for the parametrised control sequencer.
// Contents: state enum with fixed encodings, ST_W, and default parameter values.
package ctrl_seq_pkg;

    localparam int unsigned ST_W             = 3;
    localparam int unsigned OPC_W_DEF        = 4;
    localparam int unsigned LEN_W_DEF        = 3;
    localparam int unsigned CNT_W_DEF        = 8;
    localparam int unsigned TIMEOUT_DEF      = 16;
    localparam int unsigned REPEAT_LIMIT_DEF = 5;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

endpackage

// File: rtl/opc_repeat_mon.sv
// Consecutive-opcode repeat monitor.
// Ports: clk, rst (async, active-high), dec (one-cycle decode strobe),
//        opcode (opcode being decoded), clr (clears history and alarm),
//        alarm (sticky flag, set once REPEAT_LIMIT identical opcodes decode back to back).
module opc_repeat_mon
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned OPC_W        = OPC_W_DEF,
    parameter int unsigned REPEAT_LIMIT = REPEAT_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec,
    input  logic [OPC_W-1:0] opcode,
    input  logic             clr,
    output logic             alarm
);

    localparam int unsigned RC_W = $clog2(REPEAT_LIMIT + 1);

    logic [OPC_W-1:0] last_opc;
    logic             last_vld;
    logic [RC_W-1:0]  rep_cnt;
    logic [RC_W-1:0]  rep_nxt;

    // Run length including the opcode now decoding; saturates at the limit.
    always_comb begin
        rep_nxt = RC_W'(1);
        if (last_vld && (opcode == last_opc)) begin
            rep_nxt = (rep_cnt == RC_W'(REPEAT_LIMIT)) ? rep_cnt : rep_cnt + RC_W'(1);
        end
    end

    // History registers; clear takes priority over a coincident decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_opc <= '0;
            last_vld <= 1'b0;
            rep_cnt  <= '0;
            alarm    <= 1'b0;
        end else if (clr) begin
            last_vld <= 1'b0;
            rep_cnt  <= '0;
            alarm    <= 1'b0;
        end else if (dec) begin
            last_opc <= opcode;
            last_vld <= 1'b1;
            rep_cnt  <= rep_nxt;
            if (rep_nxt >= RC_W'(REPEAT_LIMIT)) begin
                alarm <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctrl_seq_param.sv
// Parametrised multi-cycle control sequencer: FETCH (handshake + timeout),
// DECODE, stallable variable-length EXEC, WB, with a TRAP state on fetch timeout.
// Ports: clk, rst (async, active-high); run, mem_ack, opcode, exec_len, stall,
//        clr_alarm inputs; state_o, mem_req, busy, exec_phase, wb_en, instr_cnt,
//        timeout, repeat_alarm outputs (all flop-driven).
module ctrl_seq_param
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned OPC_W        = OPC_W_DEF,
    parameter int unsigned LEN_W        = LEN_W_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned TIMEOUT      = TIMEOUT_DEF,
    parameter int unsigned REPEAT_LIMIT = REPEAT_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             mem_ack,
    input  logic [OPC_W-1:0] opcode,
    input  logic [LEN_W-1:0] exec_len,
    input  logic             stall,
    input  logic             clr_alarm,
    output logic [ST_W-1:0]  state_o,
    output logic             mem_req,
    output logic             busy,
    output logic [LEN_W-1:0] exec_phase,
    output logic             wb_en,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             timeout,
    output logic             repeat_alarm
);

    localparam int unsigned WT_W = $clog2(TIMEOUT);

    state_e           state;
    state_e           state_n;
    logic [WT_W-1:0]  wait_cnt;
    logic [OPC_W-1:0] opc_q;
    logic [LEN_W-1:0] len_q;
    logic             last_phase;

    assign state_o    = state;
    assign last_phase = (exec_phase == len_q - LEN_W'(1));

    // Next-state selection.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (run) state_n = ST_FETCH;
            ST_FETCH: begin
                if (mem_ack)                                state_n = ST_DECODE;
                else if (wait_cnt == WT_W'(TIMEOUT - 1))    state_n = ST_TRAP;
            end
            ST_DECODE: state_n = ST_EXEC;
            ST_EXEC:   if (!stall && last_phase) state_n = ST_WB;
            ST_WB:     state_n = run ? ST_FETCH : ST_IDLE;
            ST_TRAP:   if (clr_alarm) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            opc_q      <= '0;
            len_q      <= '0;
            exec_phase <= '0;
            instr_cnt  <= '0;
            mem_req    <= 1'b0;
            busy       <= 1'b0;
            wb_en      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state   <= state_n;
            mem_req <= (state_n == ST_FETCH);
            busy    <= (state_n != ST_IDLE) && (state_n != ST_TRAP);
            wb_en   <= (state_n == ST_WB);
            timeout <= (state_n == ST_TRAP);

            // Free-runs only while fetching, so every FETCH entry starts at 0.
            wait_cnt <= (state == ST_FETCH) ? wait_cnt + WT_W'(1) : '0;

            if ((state == ST_FETCH) && mem_ack) begin
                opc_q <= opcode;
                len_q <= (exec_len == '0) ? LEN_W'(1) : exec_len;
            end

            // Phase is held at 0 outside EXEC so it doubles as the output.
            if (state_n == ST_EXEC) begin
                if ((state == ST_EXEC) && !stall) begin
                    exec_phase <= exec_phase + LEN_W'(1);
                end
            end else begin
                exec_phase <= '0;
            end

            if (state == ST_WB) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

    opc_repeat_mon #(
        .OPC_W        (OPC_W),
        .REPEAT_LIMIT (REPEAT_LIMIT)
    ) u_rep_mon (
        .clk    (clk),
        .rst    (rst),
        .dec    (state == ST_DECODE),
        .opcode (opc_q),
        .clr    (clr_alarm),
        .alarm  (repeat_alarm)
    );

endmodule

// File: tb/tb_ctrl_seq_param.sv
// Self-checking bench for ctrl_seq_param: directed scenarios plus randomized
// instruction streams, compared against a transaction-level expectation model.
module tb_ctrl_seq_param;

    localparam int unsigned OPC_W        = 4;
    localparam int unsigned LEN_W        = 3;
    localparam int unsigned CNT_W        = 8;
    localparam int unsigned TIMEOUT      = 16;
    localparam int unsigned REPEAT_LIMIT = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic             mem_ack;
    logic [OPC_W-1:0] opcode;
    logic [LEN_W-1:0] exec_len;
    logic             stall;
    logic             clr_alarm;
    logic [2:0]       state_o;
    logic             mem_req;
    logic             busy;
    logic [LEN_W-1:0] exec_phase;
    logic             wb_en;
    logic [CNT_W-1:0] instr_cnt;
    logic             timeout;
    logic             repeat_alarm;

    int errors = 0;
    int checks = 0;

    // Model state: retired count, sticky alarm, recent decoded opcodes.
    int m_cnt   = 0;
    bit m_alarm = 1'b0;
    int hist[$];
    bit idle    = 1'b1;

    always #5 clk = ~clk;

    ctrl_seq_param #(
        .OPC_W        (OPC_W),
        .LEN_W        (LEN_W),
        .CNT_W        (CNT_W),
        .TIMEOUT      (TIMEOUT),
        .REPEAT_LIMIT (REPEAT_LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .mem_ack      (mem_ack),
        .opcode       (opcode),
        .exec_len     (exec_len),
        .stall        (stall),
        .clr_alarm    (clr_alarm),
        .state_o      (state_o),
        .mem_req      (mem_req),
        .busy         (busy),
        .exec_phase   (exec_phase),
        .wb_en        (wb_en),
        .instr_cnt    (instr_cnt),
        .timeout      (timeout),
        .repeat_alarm (repeat_alarm)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Length of the run of identical opcodes ending with the newest decode.
    function automatic int trailing_run();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == hist[hist.size() - 1]) n++;
            else break;
        end
        return n;
    endfunction

    function automatic void model_decode(input int opc);
        hist.push_back(opc);
        if (hist.size() > 8) void'(hist.pop_front());
        if (trailing_run() >= int'(REPEAT_LIMIT)) m_alarm = 1'b1;
    endfunction

    function automatic void model_clear();
        hist.delete();
        m_alarm = 1'b0;
    endfunction

    // Advance one clock and compare every output with the expected state.
    task automatic expect_cycle(input int st, input int ph, input bit wb);
        @(posedge clk);
        #1;
        check("state",     32'(state_o),      32'(st));
        check("mem_req",   32'(mem_req),      32'(st == 1));
        check("busy",      32'(busy),         32'(st != 0 && st != 5));
        check("phase",     32'(exec_phase),   32'(ph));
        check("wb_en",     32'(wb_en),        32'(wb));
        check("instr_cnt", 32'(instr_cnt),    32'(m_cnt % (1 << CNT_W)));
        check("timeout",   32'(timeout),      32'(st == 5));
        check("alarm",     32'(repeat_alarm), 32'(m_alarm));
    endtask

    // One full instruction; the next edge must enter FETCH when called.
    // d = FETCH cycles before ack, nst = stall cycles, front = stall up front.
    task automatic do_instr(input int opc, input int len, input int d, input int nst,
                            input bit front, input bit keep);
        int L;
        int p;
        int s;
        bit sv;
        L = (len == 0) ? 1 : len;
        opcode   = OPC_W'(opc);
        exec_len = LEN_W'(len);
        for (int i = 0; i <= d; i++) begin
            expect_cycle(1, 0, 0);
            mem_ack = (i == d);
        end
        expect_cycle(2, 0, 0);
        mem_ack  = 1'b0;
        opcode   = OPC_W'($urandom);
        exec_len = LEN_W'($urandom);
        model_decode(opc);
        p = 0;
        s = nst;
        forever begin
            expect_cycle(3, p, 0);
            run = keep;
            sv = (s > 0) && (front || ($urandom_range(0, 1) == 1));
            stall = sv;
            if (sv) s--;
            else if (p == L - 1) break;
            else p++;
        end
        expect_cycle(4, 0, 1);
        stall = 1'b0;
        m_cnt++;
        if (!keep) expect_cycle(0, 0, 0);
        idle = !keep;
    endtask

    task automatic clr_idle();
        clr_alarm = 1'b1;
        model_clear();
        expect_cycle(0, 0, 0);
        clr_alarm = 1'b0;
    endtask

    // No ack for TIMEOUT FETCH cycles, sit in TRAP, then ack + clear together.
    task automatic timeout_seq();
        mem_ack = 1'b0;
        for (int i = 0; i < int'(TIMEOUT); i++) expect_cycle(1, 0, 0);
        run = 1'b0;
        for (int i = 0; i < 3; i++) expect_cycle(5, 0, 0);
        check("trap_busy", 32'(busy), 32'(0));
        mem_ack   = 1'b1;
        clr_alarm = 1'b1;
        model_clear();
        expect_cycle(0, 0, 0);
        check("trap_exit_timeout", 32'(timeout), 32'(0));
        mem_ack   = 1'b0;
        clr_alarm = 1'b0;
        expect_cycle(0, 0, 0);
        idle = 1'b1;
    endtask

    task automatic reset_mid_exec();
        run = 1'b1;
        opcode   = OPC_W'(5);
        exec_len = LEN_W'(4);
        expect_cycle(1, 0, 0);
        mem_ack = 1'b1;
        expect_cycle(2, 0, 0);
        mem_ack = 1'b0;
        model_decode(5);
        expect_cycle(3, 0, 0);
        expect_cycle(3, 1, 0);
        #2;
        run = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_state",   32'(state_o),      32'(0));
        check("rst_mem_req", 32'(mem_req),      32'(0));
        check("rst_busy",    32'(busy),         32'(0));
        check("rst_phase",   32'(exec_phase),   32'(0));
        check("rst_wb_en",   32'(wb_en),        32'(0));
        check("rst_cnt",     32'(instr_cnt),    32'(0));
        check("rst_timeout", 32'(timeout),      32'(0));
        check("rst_alarm",   32'(repeat_alarm), 32'(0));
        m_cnt = 0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_cycle(0, 0, 0);
        idle = 1'b1;
    endtask

    initial begin
        int d;
        bit keep;
        rst = 1'b1; run = 1'b0; mem_ack = 1'b0; stall = 1'b0; clr_alarm = 1'b0;
        opcode = '0; exec_len = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(state_o),   32'(0));
        check("reset_busy",  32'(busy),      32'(0));
        check("reset_cnt",   32'(instr_cnt), 32'(0));
        rst = 1'b0;
        expect_cycle(0, 0, 0);

        // Basic flow: opcode 3, length 2, ack on first FETCH, run kept high.
        run = 1'b1;
        do_instr(3, 2, 0, 0, 1'b0, 1'b1);
        do_instr(4, 1, 0, 0, 1'b0, 1'b0);

        run = 1'b1;
        timeout_seq();

        // Ack arrives on the last allowed FETCH cycle.
        run = 1'b1;
        do_instr(1, 3, int'(TIMEOUT) - 1, 0, 1'b0, 1'b0);

        // Repeat monitor scenarios.
        clr_idle();
        run = 1'b1;
        for (int i = 0; i < 5; i++) do_instr(7, 1, $urandom_range(0, 2), 0, 1'b0, i < 4);
        check("rep_five", 32'(repeat_alarm), 32'(1));
        clr_idle();
        run = 1'b1;
        for (int i = 0; i < 5; i++) do_instr((i < 4) ? 7 : 2, 1, 0, 0, 1'b0, i < 4);
        check("rep_four_then_other", 32'(repeat_alarm), 32'(0));
        clr_idle();
        run = 1'b1;
        for (int i = 0; i < 4; i++) do_instr(7, 1, 0, 0, 1'b0, i < 3);
        check("rep_after_clear", 32'(repeat_alarm), 32'(0));

        // Length 0 with three front stall cycles, then the longest length.
        run = 1'b1;
        do_instr(9, 0, 0, 3, 1'b1, 1'b1);
        do_instr(10, 7, 0, 0, 1'b0, 1'b0);

        // Randomized instruction stream.
        for (int k = 0; k < 60; k++) begin
            if (idle && ($urandom_range(0, 3) == 0)) clr_idle();
            if (idle) run = 1'b1;
            d = ($urandom_range(0, 7) == 0) ? int'(TIMEOUT) - 1 : $urandom_range(0, 3);
            keep = (k < 59) && ($urandom_range(0, 1) == 1);
            do_instr($urandom_range(0, 3), $urandom_range(0, 7), d,
                     $urandom_range(0, 3), 1'b0, keep);
        end

        reset_mid_exec();

        // 2^CNT_W back-to-back instructions wrap the retired counter.
        run = 1'b1;
        for (int i = 0; i < (1 << CNT_W); i++) begin
            do_instr($urandom_range(0, 15), 1, 0, 0, 1'b0, i < (1 << CNT_W) - 1);
        end
        check("cnt_wrap", 32'(instr_cnt), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
